// File: rtl/glow_v1_pkg.sv
// Shared Glow v1 definitions for the multicycle mul/div engine: op encodings,
// ALU opcode mapping and engine state type.
package glow_v1_pkg;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MUL_LO = 2'd0;
  localparam md_op_t MD_MUL_HI = 2'd1;
  localparam md_op_t MD_DIV    = 2'd2;
  localparam md_op_t MD_MOD    = 2'd3;

  localparam logic [7:0] ALU_OP_MULLO = 8'h0f;
  localparam logic [7:0] ALU_OP_MULHI = 8'h10;
  localparam logic [7:0] ALU_OP_DIV   = 8'h11;
  localparam logic [7:0] ALU_OP_MOD   = 8'h12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // Only meaningful for the four multicycle ALU opcodes; others fall to MOD.
  function automatic md_op_t alu_to_md(input logic [7:0] alu_op);
    case (alu_op)
      ALU_OP_MULLO: return MD_MUL_LO;
      ALU_OP_MULHI: return MD_MUL_HI;
      ALU_OP_DIV:   return MD_DIV;
      default:      return MD_MOD;
    endcase
  endfunction

endpackage

// File: rtl/glow_v1_muldiv_if.sv
// Request/response bundle between the ALU (master) and the mul/div engine (slave).
interface glow_v1_muldiv_if
  import glow_v1_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             finish;
  logic [WIDTH-1:0] result;

  modport master (output start, op, opa, opb, input busy, finish, result);
  modport slave  (input start, op, opa, opb, output busy, finish, result);
endinterface

// File: rtl/glow_v1_muldiv.sv
// Iterative unsigned multiply (shift-and-add) / divide (restoring) engine.
// One WIDTH+2-bit adder is shared: add for multiply, subtract for divide.
module glow_v1_muldiv
  import glow_v1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  glow_v1_muldiv_if.slave  md
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t        state;
  logic [CW-1:0]    cnt;
  md_op_t           op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc;     // product high half / partial remainder
  logic [WIDTH-1:0] lo;      // product low half / quotient
  logic             busy_q, finish_q;
  logic [WIDTH-1:0] result_q;

  logic             is_div, last;
  logic [WIDTH:0]   x, y;
  logic [WIDTH+1:0] y_eff, sum;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] lo_nx, res_nx;

  assign is_div = (op_q == MD_DIV) || (op_q == MD_MOD);
  assign last   = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    x      = is_div ? {acc[WIDTH-1:0], lo[WIDTH-1]} : acc;
    y      = (is_div || lo[0]) ? {1'b0, b_q} : '0;
    y_eff  = is_div ? ~{1'b0, y} : {1'b0, y};
    sum    = {1'b0, x} + y_eff + {{(WIDTH+1){1'b0}}, is_div};
    acc_nx = {1'b0, sum[WIDTH:1]};
    lo_nx  = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      // sum MSB set means the trial subtraction went negative: restore
      acc_nx = sum[WIDTH+1] ? x : sum[WIDTH:0];
      lo_nx  = {lo[WIDTH-2:0], ~sum[WIDTH+1]};
    end
    case (op_q)
      MD_MUL_LO: res_nx = lo_nx;
      MD_MUL_HI: res_nx = acc_nx[WIDTH-1:0];
      MD_DIV:    res_nx = lo_nx;
      default:   res_nx = acc_nx[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= MD_MUL_LO;
      b_q      <= '0;
      acc      <= '0;
      lo       <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      result_q <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state)
        ST_RUN: begin
          acc <= acc_nx;
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            state    <= ST_DONE;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
            result_q <= res_nx;
          end
        end
        default: begin
          if (md.start) begin
            state  <= ST_RUN;
            busy_q <= 1'b1;
            op_q   <= md.op;
            b_q    <= md.opb;
            acc    <= '0;
            lo     <= md.opa;
            cnt    <= '0;
          end else begin
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign md.busy   = busy_q;
  assign md.finish = finish_q;
  assign md.result = result_q;

endmodule

// File: tb/tb_glow_v1_muldiv.sv
// Self-checking bench: arithmetic reference model with cycle-accurate finish/busy
// expectations, directed corner cases and randomized operations.
module tb_glow_v1_muldiv;
  import glow_v1_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  glow_v1_muldiv_if #(.WIDTH(W)) md ();
  glow_v1_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .md(md));

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } exp_t;

  exp_t         q[$];
  int           cyc   = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] held  = '0;
  bit           ef;

  function automatic logic [W-1:0] model(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned pa, pb, p;
    pa = a; pb = b; p = pa * pb;
    case (op)
      MD_MUL_LO: return W'(p);
      MD_MUL_HI: return W'(p >> W);
      MD_DIV:    return (pb == 0) ? '1 : W'(pa / pb);
      default:   return (pb == 0) ? a  : W'(pa % pb);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, sampled 2 time units after the edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    if (!rst) begin
      chk("rst_busy", {31'b0, md.busy}, 0);
      chk("rst_finish", {31'b0, md.finish}, 0);
      chk("rst_result", {24'b0, md.result}, 0);
    end else begin
      ef = (q.size() > 0) && (q[0].due == cyc);
      chk("finish", {31'b0, md.finish}, {31'b0, ef});
      if (ef) begin
        held = q[0].val;
        void'(q.pop_front());
      end
      chk("busy", {31'b0, md.busy}, {31'b0, (q.size() > 0) && (q[0].due > cyc)});
      chk("result", {24'b0, md.result}, {24'b0, held});
    end
  end

  // Called at a negedge; drives a one-cycle start and scrambles inputs afterwards.
  task automatic issue(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
    exp_t e;
    md.start = 1'b1; md.op = op; md.opa = a; md.opb = b;
    if (accept) begin
      e.due = cyc + 9;
      e.val = model(op, a, b);
      q.push_back(e);
    end
    @(negedge clk);
    md.start = 1'b0;
    md.op    = md_op_t'($urandom);
    md.opa   = W'($urandom);
    md.opb   = W'($urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30 && q.size() > 0; k++) @(negedge clk);
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  int c0;

  initial begin
    md.start = 1'b0; md.op = MD_MUL_LO; md.opa = '0; md.opb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(MD_MUL_LO, 8'hFF, 8'hFF, 1); wait_done(); chk("mul_lo_ff", md.result, 8'h01);
    issue(MD_MUL_HI, 8'hFF, 8'hFF, 1); wait_done(); chk("mul_hi_ff", md.result, 8'hFE);
    issue(MD_DIV, 8'd200, 8'd7, 1);    wait_done(); chk("div_200_7", md.result, 8'h1C);
    issue(MD_MOD, 8'd200, 8'd7, 1);    wait_done(); chk("mod_200_7", md.result, 8'h04);
    issue(MD_DIV, 8'd5, 8'd9, 1);      wait_done(); chk("div_5_9", md.result, 8'h00);
    issue(MD_MOD, 8'd5, 8'd9, 1);      wait_done(); chk("mod_5_9", md.result, 8'h05);
    issue(MD_DIV, 8'h5A, 8'h00, 1);    wait_done(); chk("div_by0", md.result, 8'hFF);
    issue(MD_MOD, 8'h5A, 8'h00, 1);    wait_done(); chk("mod_by0", md.result, 8'h5A);

    // start pulsed in RUN cycle 4 must be ignored
    c0 = cyc;
    issue(MD_MUL_LO, 8'd3, 8'd4, 1);
    while (cyc < c0 + 4) @(negedge clk);
    issue(MD_DIV, 8'd100, 8'd3, 0);
    wait_done();
    chk("busy_prot", md.result, 8'h0C);
    repeat (12) @(negedge clk);
    chk("busy_prot_hold", md.result, 8'h0C);

    // back-to-back issue in the DONE cycle
    issue(MD_DIV, 8'd100, 8'd3, 1); wait_done(); chk("b2b_div", md.result, 8'h21);
    issue(MD_MOD, 8'd100, 8'd3, 1); wait_done(); chk("b2b_mod", md.result, 8'h01);

    // asynchronous reset during RUN cycle 5 aborts the op
    c0 = cyc;
    issue(MD_MUL_LO, 8'd3, 8'd4, 1);
    while (cyc < c0 + 5) @(negedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    held = '0;
    #1;
    chk("async_busy", {31'b0, md.busy}, 0);
    chk("async_result", md.result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    issue(MD_MUL_HI, 8'h10, 8'h10, 1); wait_done(); chk("post_rst_mulhi", md.result, 8'h01);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0]   alu_op;
      logic [W-1:0] a, b;
      alu_op = ALU_OP_MULLO + 8'($urandom_range(0, 3));
      a      = W'($urandom);
      b      = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      issue(alu_to_md(alu_op), a, b, 1);
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/glow_v1_muldiv.md
Name: glow_v1_muldiv

Overview:
- Multicycle unsigned multiply/divide engine for the Glow v1 CPU datapath.
- Answers the ALU's multicycle requests: ALU opcodes 0x0f/0x10 (product low/high byte) and 0x11/0x12 (quotient/remainder).
- Returns a one-cycle finish strobe, which the ALU uses as OpFinish, together with an 8-bit result.
- Single iterative datapath: shift-and-add for multiply, restoring shift-and-subtract for divide.

Parameters:
- WIDTH, 8, operand and result width. Iteration count equals WIDTH; the counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request strobe from the ALU. Accepted only in IDLE or DONE.
- op  input  2  0=MUL_LO, 1=MUL_HI, 2=DIV, 3=MOD. Sampled with start.
- opa  input  WIDTH  operand A (multiplicand/dividend). Sampled with start.
- opb  input  WIDTH  operand B (multiplier/divisor). Sampled with start.
- busy  output  1  high while in RUN.
- finish  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  selected result byte. Held until the next accepted start.

Behaviour:
- Reset (rst low, asynchronous):
  - state returns to IDLE.
  - busy=0, finish=0, result=0.
  - Counter and internal registers are cleared.
  - A reset during RUN aborts the operation; no finish is produced.
- States:
  - IDLE: start -> RUN. Latch op/opa/opb and clear the accumulator in the same edge.
  - RUN: one iteration per cycle; counter counts 0..WIDTH-1. At count WIDTH-1 -> DONE.
  - DONE: finish=1 for exactly this cycle and result is registered. Next state is RUN if start=1, otherwise IDLE.
- Latency:
  - start sampled at edge T; RUN occupies cycles T+1..T+WIDTH; finish is high in cycle T+WIDTH+1.
  - With WIDTH=8, finish comes 9 cycles after start.
  - Back-to-back start in DONE gives a 9-cycle issue interval.
- start while in RUN is ignored. Operands and op are not re-sampled, and no error is flagged.
- op changes after start have no effect; only latched values are used.
- Multiply:
  - 2*WIDTH-bit product register {hi, lo}, initialised to {0, opa}.
  - Each iteration: if lo[0], add opb into hi with carry out. Then shift the {carry, hi, lo} right by 1.
  - MUL_LO returns product[WIDTH-1:0]; MUL_HI returns product[2*WIDTH-1:WIDTH].
- Divide:
  - Remainder register is WIDTH+1 bits, quotient register is WIDTH bits, initialised to {0, opa}.
  - Each iteration: shift {rem, quo} left by 1, then trial = rem - {0, opb}.
  - If trial is non-negative, rem = trial and quo[0] = 1; otherwise restore.
  - DIV returns quo; MOD returns rem[WIDTH-1:0].
- Divide by zero is not trapped. The algorithm naturally yields quo=all ones (0xFF) and rem=opa; this is the required result.
- result updates only on the RUN->DONE edge. It holds its value through IDLE and through the RUN of a later operation until that operation's DONE.
- finish and busy are never high in the same cycle.
- All arithmetic is unsigned. No flags output; the ALU carry is unaffected.

Decomposition:
- Shared package glow_v1_pkg holds:
  - the op encoding constants (MD_MUL_LO, MD_MUL_HI, MD_DIV, MD_MOD);
  - the ALU opcode constants 0x0f..0x12 and the ALU-op-to-md-op mapping;
  - the state typedef (IDLE, RUN, DONE).
- No sub-module is needed. The single WIDTH+1-bit add/subtract datapath is shared between multiply and divide inside this block.

Test Plan:
- MUL: opa=0xFF, opb=0xFF, op=MUL_LO, then op=MUL_HI -> result 0x01, then 0xFE. finish exactly 9 cycles after each start; busy high for 8 cycles.
- DIV/MOD: opa=200 (0xC8), opb=7 -> DIV 0x1C, MOD 0x04. Also opa=5, opb=9 -> DIV 0x00, MOD 0x05.
- Divide by zero: opa=0x5A, opb=0x00 -> DIV 0xFF, MOD 0x5A. No hang; finish at cycle 9.
- Busy protection: start MUL_LO 3x4, then pulse start with DIV 100/3 in RUN cycle 4 -> single finish, result 0x0C, no second finish. Back-to-back: start asserted in the DONE cycle -> next finish 9 cycles later, correct result.
- Reset mid-operation: assert rst low during RUN cycle 5 -> busy/finish/result go to 0 immediately (asynchronous). No finish after release. Next op 0x10*0x10 MUL_HI -> 0x01.
- Random: 2000 random opa/opb/op vs a reference model, with opb=0 forced in 10% of trials -> all results match. result is stable between finish pulses.
